crc_gen_5bit_tx: RTL and testbench

//  Transmit-side counterpart of the 5-bit USB token CRC checker.
//  - Accepts an 11-bit token payload ({ENDP,ADDR} or SOF frame number) and serialises it LSB first.
//  - Appends the ones-complement CRC5 (poly x^5+x^2+1, init 5'b11111), highest-order CRC bit first.
//  - Sits between the token packet builder and the NRZI/bit-stuff transmit path; advances one bit per shift_enable.

---
 rtl/crc_gen_5bit_tx_if.sv | 32 +++
 rtl/crc_gen_5bit_tx.sv | 122 ++++++++++++
 tb/tb_crc_gen_5bit_tx.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/crc_gen_5bit_tx_if.sv
// Bus bundle for the USB token CRC5 transmitter: start/payload request, bit strobe and serial results.
// err_inject exists only when CRC5_ERR_INJECT_EN is defined.
interface crc_gen_5bit_tx_if #(
    parameter int PAYLOAD_BITS = 11
);
    logic                    start;
    logic [PAYLOAD_BITS-1:0] payload;
    logic                    shift_enable;
`ifdef CRC5_ERR_INJECT_EN
    logic                    err_inject;
`endif
    logic                    serial_out;
    logic                    busy;
    logic                    done;
    logic [4:0]              crc_out;

    modport master (
        output start, payload, shift_enable,
`ifdef CRC5_ERR_INJECT_EN
        output err_inject,
`endif
        input  serial_out, busy, done, crc_out
    );

    modport slave (
        input  start, payload, shift_enable,
`ifdef CRC5_ERR_INJECT_EN
        input  err_inject,
`endif
        output serial_out, busy, done, crc_out
    );
endinterface

// File: rtl/crc_gen_5bit_tx.sv
// USB token CRC5 transmitter: serialises an 11-bit payload LSB first, then the complemented CRC5 MSB first.
// Optional macro CRC5_ERR_INJECT_EN adds err_inject, which sends the CRC uncomplemented.
module crc_gen_5bit_tx #(
    parameter int PAYLOAD_BITS = 11
) (
    input logic              clk,
    input logic              sync_rst,
    crc_gen_5bit_tx_if.slave bus
);
    localparam int CW = ($clog2(PAYLOAD_BITS) > 3) ? $clog2(PAYLOAD_BITS) : 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state_r;
    logic [PAYLOAD_BITS-1:0] shreg_r;
    logic [4:0]              crc_r;
    logic [CW-1:0]           cnt_r;
    logic                    inject_r;
    logic                    serial_out_r;
    logic                    busy_r;
    logic                    done_r;
    logic [4:0]              crc_out_r;
    logic [4:0]              crc_next_s;
    logic                    inject_in_s;

    function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic d);
        logic fb;
        fb = c[4] ^ d;
        return {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
    endfunction

`ifdef CRC5_ERR_INJECT_EN
    assign inject_in_s = bus.err_inject;
`else
    assign inject_in_s = 1'b0;
`endif

    assign crc_next_s = crc5_step(crc_r, shreg_r[0]);

    // Frame sequencer; serial_out is registered one bit ahead so it is valid the cycle after each strobe.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_r      <= IDLE;
            shreg_r      <= '0;
            crc_r        <= 5'b11111;
            cnt_r        <= '0;
            inject_r     <= 1'b0;
            serial_out_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            crc_out_r    <= 5'b00000;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        shreg_r      <= bus.payload;
                        crc_r        <= 5'b11111;
                        cnt_r        <= '0;
                        inject_r     <= inject_in_s;
                        serial_out_r <= bus.payload[0];
                        busy_r       <= 1'b1;
                        state_r      <= DATA;
                    end else begin
                        serial_out_r <= 1'b0;
                        busy_r       <= 1'b0;
                    end
                end
                DATA: begin
                    if (bus.shift_enable) begin
                        crc_r   <= crc_next_s;
                        shreg_r <= shreg_r >> 1;
                        if (cnt_r == CW'(PAYLOAD_BITS - 1)) begin
                            cnt_r        <= '0;
                            serial_out_r <= ~crc_next_s[4] ^ inject_r;
                            state_r      <= CRC;
                        end else begin
                            cnt_r        <= cnt_r + CW'(1);
                            serial_out_r <= shreg_r[1];
                        end
                    end
                end
                // CRC register is frozen here; only the bit index advances.
                CRC: begin
                    if (bus.shift_enable) begin
                        if (cnt_r == CW'(4)) begin
                            cnt_r        <= '0;
                            serial_out_r <= 1'b0;
                            busy_r       <= 1'b0;
                            done_r       <= 1'b1;
                            crc_out_r    <= ~crc_r ^ {5{inject_r}};
                            state_r      <= DONE;
                        end else begin
                            cnt_r        <= cnt_r + CW'(1);
                            serial_out_r <= ~crc_r[3'd3 - cnt_r[2:0]] ^ inject_r;
                        end
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r      <= IDLE;
                    serial_out_r <= 1'b0;
                    busy_r       <= 1'b0;
                    done_r       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.serial_out = serial_out_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.crc_out    = crc_out_r;
endmodule

// File: tb/tb_crc_gen_5bit_tx.sv
// Scoreboard bench for crc_gen_5bit_tx: stimulus pushes hand-computed bit streams and CRCs,
// a negedge monitor compares the serial stream, done/crc_out and a loopback CRC5 checker verdict.
module tb_crc_gen_5bit_tx;
    logic clk = 1'b0;
    logic sync_rst;
    int   total = 0;
    int   bad = 0;
    int   frames_done = 0;

    logic       exp_bits[$];
    logic [4:0] exp_crc[$];
    bit         exp_pass[$];
    logic [4:0] resid;
    int         nbits;

    always #5 clk = ~clk;

    crc_gen_5bit_tx_if #(.PAYLOAD_BITS(11)) bus ();

    crc_gen_5bit_tx #(.PAYLOAD_BITS(11)) dut (
        .clk      (clk),
        .sync_rst (sync_rst),
        .bus      (bus.slave)
    );

    function automatic logic [4:0] chk_step(input logic [4:0] c, input logic d);
        logic fb;
        fb = c[4] ^ d;
        return {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every presented bit, pops on consumption, checks the done pulse.
    initial begin
        resid = 5'b11111;
        nbits = 0;
        forever begin
            @(negedge clk);
            if (sync_rst) begin
                exp_bits.delete();
                exp_crc.delete();
                exp_pass.delete();
                resid = 5'b11111;
                nbits = 0;
            end else begin
                if (bus.busy) begin
                    if (exp_bits.size() == 0) begin
                        check("busy without frame", 16'(bus.busy), 16'd0);
                    end else begin
                        check("serial bit", 16'(bus.serial_out), 16'(exp_bits[0]));
                        if (bus.shift_enable) begin
                            resid = chk_step(resid, bus.serial_out);
                            nbits++;
                            void'(exp_bits.pop_front());
                        end
                    end
                end
                if (bus.done) begin
                    if (exp_crc.size() == 0) begin
                        check("unexpected done", 16'(bus.done), 16'd0);
                    end else begin
                        check("crc_out", 16'(bus.crc_out), 16'(exp_crc.pop_front()));
                        check("bits per frame", 16'(nbits), 16'd16);
                        check("checker verdict", 16'(resid == 5'b01100), 16'(exp_pass.pop_front()));
                        check("busy at done", 16'(bus.busy), 16'd0);
                        check("serial at done", 16'(bus.serial_out), 16'd0);
                    end
                    resid = 5'b11111;
                    nbits = 0;
                    frames_done++;
                end
            end
        end
    end

    task automatic run_frame(input logic [10:0] p, input logic [4:0] c, input int period,
                             input bit inj, input bit poke);
        int cyc;
        int base;
        for (int i = 0; i < 11; i++) exp_bits.push_back(p[i]);
        for (int i = 4; i >= 0; i--) exp_bits.push_back(c[i]);
        exp_crc.push_back(c);
        exp_pass.push_back(!inj);
        base = frames_done;
        @(posedge clk); #1;
        bus.start        = 1'b1;
        bus.payload      = p;
        bus.shift_enable = 1'b1;
`ifdef CRC5_ERR_INJECT_EN
        bus.err_inject   = inj;
`endif
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.payload = 11'h555;
`ifdef CRC5_ERR_INJECT_EN
        bus.err_inject = 1'b0;
`endif
        check("busy after start", 16'(bus.busy), 16'd1);
        cyc = 0;
        while (frames_done == base && cyc < 400) begin
            bus.shift_enable = ((cyc % period) == (period - 1));
            bus.start        = poke && (cyc == 6);
            bus.payload      = poke ? 11'h7FF : 11'h555;
            @(posedge clk); #1;
            cyc++;
        end
        bus.shift_enable = 1'b0;
        bus.start        = 1'b0;
        if (frames_done == base) check("frame timeout", 16'd0, 16'd1);
        @(negedge clk);
        check("done width", 16'(bus.done), 16'd0);
        check("crc_out hold", 16'(bus.crc_out), 16'(c));
    endtask

    initial begin
        bus.start        = 1'b0;
        bus.payload      = 11'h000;
        bus.shift_enable = 1'b0;
`ifdef CRC5_ERR_INJECT_EN
        bus.err_inject   = 1'b0;
`endif
        sync_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 sync_rst = 1'b0;
        @(negedge clk);
        check("reset busy", 16'(bus.busy), 16'd0);
        check("reset done", 16'(bus.done), 16'd0);
        check("reset serial", 16'(bus.serial_out), 16'd0);
        check("reset crc_out", 16'(bus.crc_out), 16'd0);

        run_frame(11'h000, 5'b01000, 1, 1'b0, 1'b0);
        run_frame(11'h7FF, 5'b00010, 1, 1'b0, 1'b0);
        run_frame(11'h000, 5'b01000, 4, 1'b0, 1'b0);
        run_frame(11'h000, 5'b01000, 1, 1'b0, 1'b1);

        // Abort mid-DATA; start held during reset must not take effect.
        for (int i = 0; i < 11; i++) exp_bits.push_back(1'((11'h123 >> i) & 11'h001));
        @(posedge clk); #1;
        bus.start   = 1'b1;
        bus.payload = 11'h123;
        @(posedge clk); #1;
        bus.start        = 1'b0;
        bus.shift_enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sync_rst    = 1'b1;
        bus.start   = 1'b1;
        bus.payload = 11'h7FF;
        repeat (2) @(posedge clk);
        #1;
        sync_rst         = 1'b0;
        bus.start        = 1'b0;
        bus.shift_enable = 1'b0;
        @(negedge clk);
        check("abort busy", 16'(bus.busy), 16'd0);
        check("abort done", 16'(bus.done), 16'd0);
        check("abort serial", 16'(bus.serial_out), 16'd0);
        check("abort crc_out", 16'(bus.crc_out), 16'd0);
        repeat (3) @(negedge clk);
        check("abort stays idle", 16'(bus.busy), 16'd0);

        run_frame(11'h7FF, 5'b00010, 1, 1'b0, 1'b0);
`ifdef CRC5_ERR_INJECT_EN
        run_frame(11'h000, 5'b10111, 1, 1'b1, 1'b0);
        run_frame(11'h7FF, 5'b11101, 2, 1'b1, 1'b0);
`endif
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
